conv_out_requant: RTL and testbench
===================================

# conv_out_requant

Requantization and output-buffering stage that sits directly downstream of the DSP-cascade convolution PE. It consumes the PE's 48-bit accumulator stream (`o_P` qualified by `o_en`), then adds a per-filter bias, applies optional ReLU, rounds, shifts right and saturates each result to int8. It tags each result with its output row/column and the frame-last flag, and buffers it in a FIFO behind a valid/ready interface. The PE has no backpressure, so this block must absorb bursts and flag any loss.

## Interface
- `FM_SIZE`, default 2: input feature-map side; matches PE.
- `KERNEL_SIZE`, default 1: kernel side; matches PE.
- `STRIDE`, default 1: matches PE.
- `OUT_SIZE`, default `(FM_SIZE-KERNEL_SIZE)/STRIDE+1`: output side.
- `FIFO_DEPTH`, default 16: power of two, ≥4.
- `i_clk`, in, 1: clock, rising edge.
- `i_rst_n`, in, 1: synchronous, active-low reset.
- `i_frame_start`, in, 1: one-cycle pulse; clears the row/col counters.
- `i_pe_en`, in, 1: PE `o_en`; 1 = `i_pe_p` valid this cycle.
- `i_pe_p`, in, 48 signed: PE `o_P`.
- `i_bias`, in, 32 signed: bias, quasi-static per frame.
- `i_shift`, in, 6: right-shift amount, 0..47, quasi-static.
- `i_relu`, in, 1: 1 = clamp negatives to 0, quasi-static.
- `o_valid`, out, 1: FIFO head valid.
- `i_ready`, in, 1: consumer accepts the head.
- `o_data`, out, 8 signed: requantized value.
- `o_row`, `o_col`, out, `$clog2(OUT_SIZE)` (min 1): position tag.
- `o_last`, out, 1: tag for the final pixel of the frame.
- `o_overflow`, out, 1: sticky; at least one result was dropped.

## Operation
- S1 (capture): on `i_pe_en`=1, register `i_pe_p` and the current (row, col); advance the counters.
  - col wraps at `OUT_SIZE-1` to 0 and row increments.
  - row wraps at `OUT_SIZE-1` to 0; `last` = (row, col) == (`OUT_SIZE-1`, `OUT_SIZE-1`).
- S2 (bias/round):
  - sum = sext49(P) + sext49(bias).
  - rnd = sum + (shift>0 ? 1<<(shift-1) : 0), computed in 50 bits.
- S3 (shift/sat):
  - q = rnd >>> shift (arithmetic).
  - With `i_relu`=1: q<0 → 0.
  - Saturate to [-128,127], or [0,127] when ReLU is enabled.
  - Write {q[7:0], row, col, last} into the FIFO.
- FIFO write when full with no read in the same cycle: drop the entry and set `o_overflow`. Write and read in the same cycle while full: both proceed, no overflow.
- Counters advance for every `i_pe_en` pulse, including dropped entries, so tags stay aligned.
- `i_frame_start` coinciding with `i_pe_en`: that sample is tagged (0,0), and the counters go to (0,1).
- Reset:
  - Counters, pipeline valids and FIFO pointers go to 0; `o_overflow`=0.
  - `o_valid`=0; `o_data`/`o_row`/`o_col`/`o_last` = 0.
  - Data in flight is discarded. Reset mid-frame requires a new `i_frame_start` before the next frame.

## Timing
- Latency: a sample taken at edge N is written to the FIFO at edge N+2. With the FIFO previously empty, `o_valid`=1 after edge N+2.
- Throughput: one result per cycle sustained while `i_ready`=1.
- Handshake: the head transfers on an edge where `o_valid`&`i_ready`.
  - `o_data` and the tags are stable while `o_valid`=1 and `i_ready`=0.
  - `o_valid` never drops without a transfer.
- Empty FIFO with `i_ready`=1 and a write arriving: the entry appears the next cycle; there is no fall-through.
- Full means exactly `FIFO_DEPTH` entries, which requires a count or an extra pointer bit.

## Structure
- Package `conv_pkg`:
  - `INT8_MAX`/`INT8_MIN` constants.
  - `out_size(fm, k, s)` function.
  - FIFO entry struct/width constant shared with the downstream writer.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): registered output, full/empty, same-cycle read+write allowed when full.
- Top level holds the counters, S1–S3 registers and the overflow flag.

## Test plan
- Arithmetic, P=1000, bias=24, shift=3, relu=0 → (1024+4)>>>3 = 128 → `o_data`=127 (saturated).
- P=-50, bias=0, shift=2:
  - relu=0 → -12.
  - relu=1 → 0.
  - P=-5000, relu=0 → -128.
- Tags, FM_SIZE=5, KERNEL_SIZE=3, STRIDE=1 (`OUT_SIZE`=3): 9 pulses after `i_frame_start` → tags (0,0)…(2,2) in order; `o_last`=1 only on the 9th. A 10th pulse is tagged (0,0).
- Overflow: `i_ready`=0, 20 back-to-back pulses, `FIFO_DEPTH`=16 → 16 entries held, `o_overflow`=1. Draining yields tags of pulses 1–16 exactly.
- Backpressure: toggle `i_ready` randomly over 100 pulses. Check no loss, no duplication, order preserved, and `o_data` stable while stalled.
- Reset: assert `i_rst_n`=0 mid-frame with 5 entries buffered → next cycle `o_valid`=0, `o_overflow`=0, all outputs 0. A new frame starts cleanly at (0,0).

Source files
------------

// File: rtl/conv_out_requant_pkg.sv
// Shared constants, helpers and FIFO entry layout for the conv output path.
package conv_pkg;

  localparam int INT8_MAX    = 127;
  localparam int INT8_MIN    = -128;
  localparam int TAG_FIELD_W = 8;

  // One buffered result; tag fields are sized for output sides up to 256.
  typedef struct packed {
    logic [7:0]             data;
    logic [TAG_FIELD_W-1:0] row;
    logic [TAG_FIELD_W-1:0] col;
    logic                   last;
  } fifo_entry_t;

  localparam int FIFO_ENTRY_W = $bits(fifo_entry_t);

  function automatic int out_size(input int fm, input int k, input int s);
    return (fm - k) / s + 1;
  endfunction

  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_out_requant_sync_fifo.sv
// Synchronous FIFO with occupancy count; simultaneous read+write allowed when full.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd    = i_rd_en & ~o_empty;
  assign w_wr    = i_wr_en & (~o_full | w_rd);

  // Head is forced to zero when empty so outputs read 0 after reset.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array, no reset needed since the head is masked when empty.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/conv_out_requant.sv
// Requantizes the PE accumulator stream to int8, tags position, buffers results.
module conv_out_requant
  import conv_pkg::*;
#(
  parameter  int FM_SIZE     = 2,
  parameter  int KERNEL_SIZE = 1,
  parameter  int STRIDE      = 1,
  parameter  int OUT_SIZE    = out_size(FM_SIZE, KERNEL_SIZE, STRIDE),
  parameter  int FIFO_DEPTH  = 16,
  localparam int TAG_W       = tag_width(OUT_SIZE)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic               i_pe_en,
  input  logic signed [47:0] i_pe_p,
  input  logic signed [31:0] i_bias,
  input  logic [5:0]         i_shift,
  input  logic               i_relu,
  output logic               o_valid,
  input  logic               i_ready,
  output logic signed [7:0]  o_data,
  output logic [TAG_W-1:0]   o_row,
  output logic [TAG_W-1:0]   o_col,
  output logic               o_last,
  output logic               o_overflow
);

  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(OUT_SIZE - 1);

  logic [TAG_W-1:0]   r_row, r_col;
  logic [TAG_W-1:0]   w_cur_row, w_cur_col, w_nxt_row, w_nxt_col;

  logic               r_s1_vld;
  logic signed [47:0] r_s1_p;
  logic [TAG_W-1:0]   r_s1_row, r_s1_col;
  logic               r_s1_last;

  logic               r_s2_vld;
  logic signed [49:0] r_s2_rnd;
  logic [TAG_W-1:0]   r_s2_row, r_s2_col;
  logic               r_s2_last;

  logic signed [48:0] w_sum;
  logic signed [49:0] w_rnd_inc;
  logic signed [49:0] w_rnd;
  logic signed [49:0] w_q;
  logic signed [7:0]  w_sat;

  fifo_entry_t        w_wr_entry;
  fifo_entry_t        w_head;
  logic               w_full, w_empty, w_rd;
  logic               r_overflow;
  logic               w_unused_tag_msbs;

  // Frame start overrides the counters so a coincident sample is tagged (0,0).
  always_comb begin
    w_cur_row = i_frame_start ? '0 : r_row;
    w_cur_col = i_frame_start ? '0 : r_col;
    w_nxt_row = w_cur_row;
    w_nxt_col = w_cur_col + TAG_W'(1);
    if (w_cur_col == LAST_IDX) begin
      w_nxt_col = '0;
      w_nxt_row = (w_cur_row == LAST_IDX) ? '0 : w_cur_row + TAG_W'(1);
    end
  end

  // Position counters advance on every PE sample, dropped or not.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_pe_en) begin
      r_row <= w_nxt_row;
      r_col <= w_nxt_col;
    end else if (i_frame_start) begin
      r_row <= '0;
      r_col <= '0;
    end
  end

  // S1: capture accumulator and its tag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_p    <= '0;
      r_s1_row  <= '0;
      r_s1_col  <= '0;
      r_s1_last <= 1'b0;
    end else begin
      r_s1_vld  <= i_pe_en;
      r_s1_p    <= i_pe_p;
      r_s1_row  <= w_cur_row;
      r_s1_col  <= w_cur_col;
      r_s1_last <= (w_cur_row == LAST_IDX) && (w_cur_col == LAST_IDX);
    end
  end

  // S2 combinational: bias add and round-half-up offset.
  always_comb begin
    w_sum     = 49'(r_s1_p) + 49'(i_bias);
    w_rnd_inc = (i_shift != 6'd0) ? (50'd1 << (i_shift - 6'd1)) : '0;
    w_rnd     = 50'(w_sum) + w_rnd_inc;
  end

  // S2 register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_rnd  <= '0;
      r_s2_row  <= '0;
      r_s2_col  <= '0;
      r_s2_last <= 1'b0;
    end else begin
      r_s2_vld  <= r_s1_vld;
      r_s2_rnd  <= w_rnd;
      r_s2_row  <= r_s1_row;
      r_s2_col  <= r_s1_col;
      r_s2_last <= r_s1_last;
    end
  end

  // S3: arithmetic shift, optional ReLU, saturate to int8 and form FIFO entry.
  always_comb begin
    w_q = r_s2_rnd >>> i_shift;
    if (i_relu && (w_q < 50'sd0))     w_sat = 8'sd0;
    else if (w_q > 50'(INT8_MAX))     w_sat = 8'(INT8_MAX);
    else if (w_q < 50'(INT8_MIN))     w_sat = 8'(INT8_MIN);
    else                              w_sat = w_q[7:0];
    w_wr_entry.data = w_sat;
    w_wr_entry.row  = TAG_FIELD_W'(r_s2_row);
    w_wr_entry.col  = TAG_FIELD_W'(r_s2_col);
    w_wr_entry.last = r_s2_last;
  end

  assign w_rd = o_valid & i_ready;

  sync_fifo #(
    .WIDTH(FIFO_ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_wr_en  (r_s2_vld),
    .i_wr_data(w_wr_entry),
    .i_rd_en  (w_rd),
    .o_rd_data(w_head),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Sticky loss flag: a write arrived while full with no room made by a read.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                            r_overflow <= 1'b0;
    else if (r_s2_vld && w_full && !w_rd)    r_overflow <= 1'b1;
  end

  assign o_valid           = ~w_empty;
  assign o_data            = w_head.data;
  assign o_row             = w_head.row[TAG_W-1:0];
  assign o_col             = w_head.col[TAG_W-1:0];
  assign o_last            = w_head.last;
  assign o_overflow        = r_overflow;
  assign w_unused_tag_msbs = ^{w_head.row, w_head.col};

endmodule

// File: tb/tb_conv_out_requant.sv
// Randomized bench for conv_out_requant with a scoreboard-based reference model.
module tb_conv_out_requant;
  import conv_pkg::*;

  localparam int FM    = 5;
  localparam int KS    = 3;
  localparam int ST    = 1;
  localparam int OS    = 3;
  localparam int DEPTH = 16;
  localparam int TW    = 2;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_frame_start = 1'b0;
  logic              i_pe_en = 1'b0;
  logic [47:0]       i_pe_p = '0;
  logic [31:0]       i_bias = '0;
  logic [5:0]        i_shift = '0;
  logic              i_relu = 1'b0;
  logic              i_ready = 1'b0;
  logic              o_valid;
  logic [7:0]        o_data;
  logic [TW-1:0]     o_row, o_col;
  logic              o_last, o_overflow;

  typedef struct {
    int d;
    int row;
    int col;
    bit last;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     n_cmp = 0, n_err = 0;
  int     m_row = 0, m_col = 0;
  int     n_sent = 0, n_recv = 0;
  bit     mon_en = 0, rand_rdy = 0, stalled = 0;
  logic [8+2*TW:0] held;
  longint cur_bias = 0;
  int     cur_shift = 0;
  bit     cur_relu = 0;

  conv_out_requant #(
    .FM_SIZE    (FM),
    .KERNEL_SIZE(KS),
    .STRIDE     (ST),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_frame_start(i_frame_start),
    .i_pe_en      (i_pe_en),
    .i_pe_p       (i_pe_p),
    .i_bias       (i_bias),
    .i_shift      (i_shift),
    .i_relu       (i_relu),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_row        (o_row),
    .o_col        (o_col),
    .o_last       (o_last),
    .o_overflow   (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requantization rule in plain integer arithmetic.
  function automatic longint ref_q(input longint p, input longint b, input int sh, input bit relu);
    longint r;
    r = p + b;
    if (sh > 0) r = r + (longint'(1) << (sh - 1));
    r = r >>> sh;
    if (relu && r < 0) r = 0;
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  task automatic set_params(input longint b, input int sh, input bit r);
    cur_bias  = b;
    cur_shift = sh;
    cur_relu  = r;
    i_bias    = b[31:0];
    i_shift   = sh[5:0];
    i_relu    = r;
  endtask

  task automatic send(input longint p, input bit fs, input bit use_exp, input int exp_d);
    exp_t e;
    if (fs) begin m_row = 0; m_col = 0; end
    e.d    = use_exp ? exp_d : int'(ref_q(p, cur_bias, cur_shift, cur_relu));
    e.row  = m_row;
    e.col  = m_col;
    e.last = (m_row == OS-1) && (m_col == OS-1);
    exp_q.push_back(e);
    n_sent++;
    if (m_col == OS-1) begin
      m_col = 0;
      m_row = (m_row == OS-1) ? 0 : m_row + 1;
    end else m_col++;
    i_pe_en = 1'b1; i_frame_start = fs; i_pe_p = p[47:0];
    @(posedge i_clk); #1;
    i_pe_en = 1'b0; i_frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic drain();
    int guard = 0;
    if (rand_rdy) begin rand_rdy = 0; @(posedge i_clk); #2; end
    i_ready = 1'b1;
    while (exp_q.size() != 0 && guard < 300) begin @(posedge i_clk); #1; guard++; end
    check("drain_left", exp_q.size(), 0);
    check("empty_after_drain", o_valid, 0);
  endtask

  function automatic longint rnd_p();
    longint x;
    if ($urandom % 2) x = longint'($urandom_range(0, 4000)) - 2000;
    else begin
      x = {$urandom(), $urandom()};
      x = (x <<< 16) >>> 16;
    end
    return x;
  endfunction

  // Random consumer backpressure.
  always @(posedge i_clk) begin
    if (rand_rdy) begin
      #1;
      i_ready = ($urandom % 4) != 0;
    end
  end

  // Output monitor: scoreboard on transfers and hold-stability while stalled.
  always @(negedge i_clk) begin
    if (mon_en) begin
      if (stalled) begin
        check("stall_valid", o_valid, 1);
        check("stall_hold", {o_data, o_row, o_col, o_last}, held);
      end
      if (o_valid && i_ready) begin
        stalled = 0;
        if (exp_q.size() == 0) check("spurious_output", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          n_recv++;
          check("data", longint'($signed(o_data)), mon_e.d);
          check("row", o_row, mon_e.row);
          check("col", o_col, mon_e.col);
          check("last", o_last, mon_e.last);
        end
      end else begin
        stalled = o_valid;
        held    = {o_data, o_row, o_col, o_last};
      end
    end else stalled = 0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    check("rst_valid", o_valid, 0);
    check("rst_data", o_data, 0);
    check("rst_row", o_row, 0);
    check("rst_col", o_col, 0);
    check("rst_last", o_last, 0);
    check("rst_ovf", o_overflow, 0);
    i_rst_n = 1'b1;
    mon_en  = 1;
    idle(1);

    // Directed arithmetic cases.
    i_ready = 1'b1;
    set_params(24, 3, 0);
    send(1000, 1, 1, 127);
    drain();
    set_params(0, 2, 0);
    send(-50, 0, 1, -12);
    send(-5000, 0, 1, -128);
    drain();
    set_params(0, 2, 1);
    send(-50, 0, 1, 0);
    drain();
    set_params(0, 0, 0);
    send(127, 0, 1, 127);
    send(-129, 0, 1, -128);
    drain();

    // Tag sequence over one frame plus one.
    for (int i = 0; i < 10; i++) send(longint'(i), i == 0, 0, 0);
    drain();
    check("ovf_after_tags", o_overflow, 0);

    // Randomized backpressure rounds, throttled so nothing is lost.
    for (int r = 0; r < 4; r++) begin
      set_params(longint'($signed($urandom)) >>> $urandom_range(0, 31),
                 int'($urandom_range(0, 47)), bit'($urandom % 2));
      rand_rdy = 1;
      for (int k = 0; k < 25; k++) begin
        int guard = 0;
        while ((n_sent - n_recv) >= 12 && guard < 1000) begin idle(1); guard++; end
        if (guard >= 1000) check("throttle_timeout", n_sent - n_recv, 0);
        if ($urandom % 3 == 0) idle(1);
        send(rnd_p(), ($urandom % 16) == 0, 0, 0);
      end
      drain();
    end
    check("ovf_after_random", o_overflow, 0);

    // Overflow: 20 pulses into a stalled 16-deep FIFO.
    i_ready = 1'b0;
    set_params(0, 4, 0);
    for (int i = 0; i < 20; i++) send(rnd_p(), 0, 0, 0);
    idle(4);
    check("ovf_flag", o_overflow, 1);
    check("ovf_valid", o_valid, 1);
    repeat (4) void'(exp_q.pop_back());
    drain();
    check("ovf_sticky", o_overflow, 1);

    // Reset mid-frame with entries buffered.
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(rnd_p(), i == 0, 0, 0);
    idle(3);
    check("pre_rst_valid", o_valid, 1);
    mon_en  = 0;
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_ovf", o_overflow, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_row", o_row, 0);
    check("mid_rst_col", o_col, 0);
    check("mid_rst_last", o_last, 0);
    exp_q.delete();
    n_sent  = 0;
    n_recv  = 0;
    i_rst_n = 1'b1;
    mon_en  = 1;
    idle(1);
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(rnd_p(), i == 0, 0, 0);
    drain();
    check("post_rst_count", n_recv, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
